// File: rtl/mux_rr_nch.sv
`default_nettype none
// ============================================================================
// Module      : mux_rr_nch
// Description : N-channel, W-bit registered multiplexer with valid/ready
//               handshakes. It selects either by round-robin arbitration
//               (mode=0) or by forced select (mode=1). A single output
//               register gives one-cycle latency.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_rr_nch #(
    parameter int NCH = 4,
    parameter int W   = 8,
    parameter int SW  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mode,
    input  logic [SW-1:0]    sel,
    input  logic [NCH-1:0]   in_val,
    input  logic [NCH*W-1:0] in_data,
    output logic [NCH-1:0]   in_rdy,
    output logic             out_val,
    output logic [W-1:0]     out_data,
    output logic [SW-1:0]    out_src,
    input  logic             out_rdy
);

    localparam logic [SW:0]   c_nch  = (SW+1)'(NCH);
    localparam logic [SW-1:0] c_last = SW'(NCH-1);

    logic             r_out_val;
    logic [W-1:0]     r_out_data;
    logic [SW-1:0]    r_out_src;
    logic [SW-1:0]    r_ptr;

    logic             w_ld;
    logic             w_xfer;
    logic [2*NCH-1:0] w_dbl;
    logic             w_rr_found;
    logic [SW:0]      w_rr_sum;
    logic [NCH-1:0]   w_rr_grant;
    logic [NCH-1:0]   w_f_grant;
    logic [NCH-1:0]   w_grant;
    logic [SW-1:0]    w_win;
    logic [W-1:0]     w_mux;
    logic [SW-1:0]    w_ptr_next;

    // The output register can take a new item when it is empty or being drained.
    assign w_ld = ~r_out_val | out_rdy;

    // Round-robin search. The valid vector is doubled and rotated so that the scan starts at ptr.
    // The first set bit then gives an offset from ptr, which is folded back into range modulo NCH.
    always_comb begin
        w_dbl      = {in_val, in_val} >> r_ptr;
        w_rr_found = 1'b0;
        w_rr_sum   = '0;
        w_rr_grant = '0;
        for (int j = 0; j < NCH; j++) begin
            if (!w_rr_found && w_dbl[j]) begin
                w_rr_found = 1'b1;
                w_rr_sum   = {1'b0, r_ptr} + (SW+1)'(j);
            end
        end
        if (w_rr_sum >= c_nch) begin
            w_rr_sum = w_rr_sum - c_nch;
        end
        for (int i = 0; i < NCH; i++) begin
            w_rr_grant[i] = w_rr_found && (w_rr_sum == (SW+1)'(i));
        end
    end

    // Forced select. A sel value at or beyond NCH matches no channel and so never grants.
    always_comb begin
        w_f_grant = '0;
        for (int i = 0; i < NCH; i++) begin
            w_f_grant[i] = (32'(sel) == 32'(i)) && in_val[i];
        end
    end

    assign w_grant = mode ? w_f_grant : w_rr_grant;
    assign in_rdy  = {NCH{rst_n & w_ld}} & w_grant;
    assign w_xfer  = |in_rdy;

    // Encode the one-hot grant into a winner index and select that channel's data.
    always_comb begin
        w_win = '0;
        w_mux = '0;
        for (int i = 0; i < NCH; i++) begin
            if (w_grant[i]) begin
                w_win = SW'(i);
                w_mux = in_data[i*W +: W];
            end
        end
    end

    // The pointer moves past the winner and wraps at NCH rather than at 2**SW.
    assign w_ptr_next = (w_win == c_last) ? '0 : (w_win + SW'(1));

    // Output register and round-robin pointer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_val  <= 1'b0;
            r_out_data <= '0;
            r_out_src  <= '0;
            r_ptr      <= '0;
        end else if (w_xfer) begin
            r_out_val  <= 1'b1;
            r_out_data <= w_mux;
            r_out_src  <= w_win;
            if (!mode) begin
                r_ptr <= w_ptr_next;
            end
        end else if (out_rdy) begin
            r_out_val <= 1'b0;
        end
    end

    assign out_val  = r_out_val;
    assign out_data = r_out_data;
    assign out_src  = r_out_src;

endmodule
`default_nettype wire

// File: doc/mux_rr_nch.md
Name: mux_rr_nch

Overview:
Parametrised N-channel, W-bit registered multiplexer with valid/ready handshakes on every input and on the output. Selection is either round-robin arbitration or a forced select (classic mux mode). A single output pipeline register gives one-cycle latency. It is used wherever several producers share one downstream consumer, for example register-file write-back or memory-request merging.

Parameters:
NCH, 4, number of input channels (2..16).
W, 8, data width per channel in bits (>=1).
SW, 2, select/source index width; constraint NCH <= 2**SW.

Ports:
clk        input   1        clock; all state updates on posedge
rst_n      input   1        synchronous reset, active-low
mode       input   1        0 = round-robin arbitration, 1 = forced select
sel        input   SW       channel index used when mode=1
in_val     input   NCH      per-channel valid; bit i belongs to channel i
in_data    input   NCH*W    packed data; channel i occupies bits [i*W +: W]
in_rdy     output  NCH      per-channel ready (combinational)
out_val    output  1        output register holds valid data
out_data   output  W        registered data
out_src    output  SW       registered index of the channel that supplied out_data
out_rdy    input   1        downstream ready

Behaviour:
- Reset: sampled on posedge when rst_n=0. Sets out_val=0, out_data=0, out_src=0, rr pointer ptr=0. While rst_n=0, in_rdy is forced to all zeros.
- Load enable: ld = !out_val | out_rdy. The output register accepts a new item only when ld=1.
- Grant, computed combinationally and one-hot (at most one bit set):
  - mode=1: grant[sel]=1 iff sel<NCH and in_val[sel]=1. Otherwise grant is all zeros. sel>=NCH never grants.
  - mode=0: scan channels ptr, ptr+1, ..., wrapping modulo NCH. The first channel with in_val=1 wins. If no channel is valid, grant is all zeros.
- in_rdy[i] = rst_n & ld & grant[i]. in_rdy is combinational from in_val, mode, sel, out_val and out_rdy. No other channel sees ready.
- Transfer on a channel: in_val[i] & in_rdy[i] at posedge. Then out_data <= in_data[i], out_src <= i, out_val <= 1.
- Output drain: out_val & out_rdy with no input transfer in the same cycle sets out_val <= 0. out_data and out_src hold their last values.
- Simultaneous drain and transfer: both occur in the same cycle. The register is refilled and out_val stays 1. Full throughput is 1 item/cycle.
- Stall: out_val=1 and out_rdy=0 gives ld=0, so all in_rdy=0. The output register is held stable, with no change to out_data or out_src.
- Pointer update: only on a mode=0 transfer, ptr <= (winner+1) mod NCH. The wrap is at NCH, not at 2**SW. ptr is unchanged in mode=1 and on cycles with no transfer.
- Latency: an input accepted at edge k appears on out_val/out_data after edge k. The consumer can take it at edge k+1.
- Mode switch: takes effect in the same cycle, because it is combinational. ptr retains its value across mode switches.
- Reset mid-operation: any item held in the output register is discarded (out_val=0). An input asserting in_val during a reset cycle is not accepted.
- Fairness: in mode=0, any continuously valid channel is granted within NCH transfers.

Test Plan:
1. Reset with in_val=4'b1111 and rst_n=0 for 2 cycles: out_val=0, out_data=0, out_src=0, in_rdy=0000 throughout. After release, the first grant goes to ch0.
2. RR fairness, NCH=4, W=8: in_data = {8'h44,8'h33,8'h22,8'h11}, in_val=1111, out_rdy=1, mode=0 for 8 cycles. out_src sequence is 0,1,2,3,0,1,2,3 and out_data is 11,22,33,44 repeating, with out_val=1 every cycle after the first.
3. RR skip and wrap: ptr=3, in_val=0101. Grant goes to ch0, then ch2, then ch0. in_rdy[1] and in_rdy[3] stay 0.
4. Forced mode: mode=1, sel=2, in_val=1111. Only in_rdy[2]=1, out_src=2 on every transfer, ptr unchanged. With sel=2 and in_val[2]=0, no transfer occurs and out_val falls to 0 after a drain.
5. Backpressure: out_val=1, out_data=8'h22, out_rdy=0 for 3 cycles with in_val=1111. in_rdy=0000 and out_data stays 22. When out_rdy rises, a drain and refill happen in the same cycle and out_val stays 1.
6. Reset mid-stream: out_val=1 with data pending, pull rst_n=0 for one edge. out_val=0 and ptr=0 at the next cycle, and the pending item is not re-presented.
